axi_burst_mem_slave: RTL and testbench

Parametrised AXI4 full-protocol slave memory. It is the synthesizable successor to the fixed 32-bit, 8-beat test slave. It adds configurable data/address/ID width and depth, FIXED/INCR/WRAP bursts, byte strobes, ID echo and SLVERR signalling. It sits behind the PS/interconnect as scratch storage for NLMS coefficient and sample buffers, and is the target of the AXI VIP master bench.

---
 rtl/axi_burst_mem_slave.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: word-addressed scratch RAM behind an AXI4 port.
// Supports FIXED/INCR/WRAP bursts, byte strobes, ID echo and SLVERR.
// Only full-width transfers are supported. The wrapper ties off
// AxSIZE/LOCK/CACHE/PROT/QOS/REGION/USER.
//
// Ports
//   ACLK, ARESET       clock, synchronous active-high reset
//   S_AXI_AW*          write address channel (ID, start byte addr, len, burst)
//   S_AXI_W*           write data channel (data, byte strobes, last)
//   S_AXI_B*           write response (echoed ID, OKAY/SLVERR)
//   S_AXI_AR*          read address channel
//   S_AXI_R*           read data channel (echoed ID, data, per-beat resp, last)
module axi_burst_mem_slave #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_ID_WIDTH   = 4,
  parameter int C_MEM_DEPTH  = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [C_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                S_AXI_AWLEN,
  input  logic [1:0]                S_AXI_AWBURST,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                      S_AXI_WLAST,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [C_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [C_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                S_AXI_ARLEN,
  input  logic [1:0]                S_AXI_ARBURST,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [C_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY
);

  localparam int NB  = C_DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  // Word index carries 9 bits of headroom so an INCR burst running past
  // the top of memory keeps counting upward and is seen as out of range.
  localparam int IW  = C_ADDR_WIDTH - OFF + 9;
  localparam int MW  = (C_MEM_DEPTH > 1) ? $clog2(C_MEM_DEPTH) : 1;
  localparam logic [IW-1:0] DEPTH_I = IW'(C_MEM_DEPTH);

  localparam logic [1:0] BT_FIXED = 2'b00;
  localparam logic [1:0] BT_INCR  = 2'b01;
  localparam logic [1:0] BT_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_LOAD, R_DATA} r_state_t;

  // Reserved burst type, or WRAP with a length other than 2/4/8/16 beats.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11) ||
           (burst == BT_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // Illegal bursts fall back to INCR addressing.
  function automatic logic [1:0] burst_mode(input logic [1:0] burst, input logic [7:0] len);
    return burst_bad(burst, len) ? BT_INCR : burst;
  endfunction

  // For a legal WRAP, len is 2^n-1 and doubles as the in-block index mask.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx, input logic [1:0] mode,
                                             input logic [7:0] len);
    logic [IW-1:0] mask, inc;
    mask = IW'(len);
    inc  = idx + IW'(1);
    case (mode)
      BT_FIXED: return idx;
      BT_WRAP:  return (idx & ~mask) | (inc & mask);
      default:  return inc;
    endcase
  endfunction

  logic [C_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  // ---------------- write channel ----------------
  w_state_t        w_state;
  logic [IW-1:0]   w_idx;
  logic [7:0]      w_len, w_cnt;
  logic [1:0]      w_mode;
  logic            w_err;
  logic            w_beat, w_oor, w_last_beat, w_err_now, w_we;

  assign w_beat      = S_AXI_WVALID && S_AXI_WREADY;
  assign w_oor       = (w_idx >= DEPTH_I);
  assign w_last_beat = (w_cnt == w_len);
  assign w_err_now   = w_err || w_oor || (S_AXI_WLAST != w_last_beat);
  assign w_we        = !ARESET && (w_state == W_DATA) && w_beat && !w_oor;

  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int b = 0; b < NB; b++)
        if (S_AXI_WSTRB[b]) mem[w_idx[MW-1:0]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BID     <= '0;
      S_AXI_BRESP   <= RESP_OK;
      w_idx         <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_mode        <= BT_INCR;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          S_AXI_AWREADY <= 1'b1;
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            S_AXI_BID     <= S_AXI_AWID;
            w_idx         <= IW'(S_AXI_AWADDR >> OFF);
            w_len         <= S_AXI_AWLEN;
            w_mode        <= burst_mode(S_AXI_AWBURST, S_AXI_AWLEN);
            w_err         <= burst_bad(S_AXI_AWBURST, S_AXI_AWLEN);
            w_cnt         <= '0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_err <= w_err_now;
            w_idx <= next_idx(w_idx, w_mode, w_len);
            // Length comes from AWLEN; WLAST only affects the response.
            if (w_last_beat) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= w_err_now ? RESP_ERR : RESP_OK;
              w_state      <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  r_state_t          r_state;
  logic [IW-1:0]     r_idx;
  logic [7:0]        r_len, r_cnt;
  logic [1:0]        r_mode;
  logic              r_err, r_oor;
  logic [C_DATA_WIDTH-1:0] rd_word;

  assign r_oor = (r_idx >= DEPTH_I);

  // Out-of-range beats read as zero. Reading here and loading RDATA on the
  // same edge as a write gives pre-write data for a same-word collision.
  always_comb begin
    rd_word = '0;
    if (!r_oor) rd_word = mem[r_idx[MW-1:0]];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RID     <= '0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OK;
      S_AXI_RLAST   <= 1'b0;
      r_idx         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_mode        <= BT_INCR;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          S_AXI_ARREADY <= 1'b1;
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RID     <= S_AXI_ARID;
            r_idx         <= IW'(S_AXI_ARADDR >> OFF);
            r_len         <= S_AXI_ARLEN;
            r_mode        <= burst_mode(S_AXI_ARBURST, S_AXI_ARLEN);
            r_err         <= burst_bad(S_AXI_ARBURST, S_AXI_ARLEN);
            r_cnt         <= '0;
            r_state       <= R_WAIT;
          end
        end
        // One idle cycle so the first beat appears two edges after AR.
        R_WAIT: r_state <= R_LOAD;
        R_LOAD: begin
          S_AXI_RVALID <= 1'b1;
          S_AXI_RDATA  <= rd_word;
          S_AXI_RRESP  <= (r_err || r_oor) ? RESP_ERR : RESP_OK;
          S_AXI_RLAST  <= (r_len == 8'd0);
          r_idx        <= next_idx(r_idx, r_mode, r_len);
          r_state      <= R_DATA;
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            if (S_AXI_RLAST) begin
              S_AXI_RVALID  <= 1'b0;
              S_AXI_RLAST   <= 1'b0;
              S_AXI_ARREADY <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              S_AXI_RDATA <= rd_word;
              S_AXI_RRESP <= (r_err || r_oor) ? RESP_ERR : RESP_OK;
              S_AXI_RLAST <= ((r_cnt + 8'd1) == r_len);
              r_cnt       <= r_cnt + 8'd1;
              r_idx       <= next_idx(r_idx, r_mode, r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Self-checking bench for axi_burst_mem_slave (default parameters).
// Stimulus tasks compute expected R beats / B responses from a word-array
// model of memory and burst addressing arithmetic. A single negedge monitor
// checks every handshaken beat and every stalled cycle against that model.
module tb_axi_burst_mem_slave;
  localparam int DW = 32, AW = 12, IDW = 4, DEPTH = 1024;

  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [IDW-1:0] S_AXI_AWID = '0, S_AXI_ARID = '0, S_AXI_BID, S_AXI_RID;
  logic [AW-1:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [7:0]     S_AXI_AWLEN = '0, S_AXI_ARLEN = '0;
  logic [1:0]     S_AXI_AWBURST = '0, S_AXI_ARBURST = '0, S_AXI_BRESP, S_AXI_RRESP;
  logic           S_AXI_AWVALID = 1'b0, S_AXI_AWREADY, S_AXI_WLAST = 1'b0, S_AXI_WVALID = 1'b0;
  logic           S_AXI_WREADY, S_AXI_BVALID, S_AXI_BREADY = 1'b1;
  logic           S_AXI_ARVALID = 1'b0, S_AXI_ARREADY, S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
  logic [DW-1:0]  S_AXI_WDATA = '0, S_AXI_RDATA;
  logic [DW/8-1:0] S_AXI_WSTRB = '0;

  always #5 ACLK = ~ACLK;

  axi_burst_mem_slave #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW), .C_ID_WIDTH(IDW), .C_MEM_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // ---------------- model ----------------
  typedef struct packed {logic [IDW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} rbeat_t;
  typedef struct packed {logic [IDW-1:0] id; logic [1:0] resp;} bbeat_t;

  logic [DW-1:0] mm [DEPTH];
  logic [DW-1:0] wdat [16];
  rbeat_t r_exp[$], r_log[$];
  bbeat_t b_exp[$];
  int     r_seen = 0;
  logic [1:0] last_bresp = 2'b11;
  bit     rr_toggle = 1'b0;

  function automatic bit burst_bad(input int len, input logic [1:0] burst);
    return burst == 2'b11 || (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Word index of beat k of a burst starting at word 'start'.
  function automatic int beat_idx(input int start, input int len, input logic [1:0] burst, input int k);
    int n;
    n = len + 1;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && !burst_bad(len, burst)) return (start / n) * n + (start % n + k) % n;
    return start + k;
  endfunction

  // bad_last >= 0 flips WLAST on that beat.
  task automatic do_write(input logic [IDW-1:0] id, input int addr, input int len, input logic [1:0] burst,
                          input logic [3:0] strb, input int bad_last);
    bit err;
    int idx, t;
    bbeat_t e;
    err = burst_bad(len, burst) || (bad_last >= 0);
    for (int k = 0; k <= len; k++) begin
      idx = beat_idx(addr / 4, len, burst, k);
      if (idx >= DEPTH) err = 1'b1;
      else for (int b = 0; b < 4; b++) if (strb[b]) mm[idx][b*8 +: 8] = wdat[k][b*8 +: 8];
    end
    e.id = id; e.resp = err ? 2'b10 : 2'b00;
    b_exp.push_back(e);

    S_AXI_AWID = id; S_AXI_AWADDR = addr[AW-1:0]; S_AXI_AWLEN = len[7:0]; S_AXI_AWBURST = burst;
    S_AXI_AWVALID = 1'b1;
    t = 0;
    while (!S_AXI_AWREADY && t < 50) begin step(); t++; end
    chk("aw_wait", 64'(t < 50), 64'd1);
    step();
    S_AXI_AWVALID = 1'b0;
    for (int k = 0; k <= len; k++) begin
      S_AXI_WDATA = wdat[k]; S_AXI_WSTRB = strb;
      S_AXI_WLAST = (k == len) ^ (k == bad_last);
      S_AXI_WVALID = 1'b1;
      t = 0;
      while (!S_AXI_WREADY && t < 50) begin step(); t++; end
      if (t >= 50) chk("w_wait", 64'(t), 64'd0);
      step();
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    chk("bvalid_after_last_w", 64'(S_AXI_BVALID), 64'd1);
    step();
    chk("awready_after_b", 64'(S_AXI_AWREADY), 64'd1);
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input int addr, input int len, input logic [1:0] burst,
                         input bit chk_lat);
    bit err;
    int idx, t;
    rbeat_t e;
    err = burst_bad(len, burst);
    for (int k = 0; k <= len; k++) begin
      idx = beat_idx(addr / 4, len, burst, k);
      e.id   = id;
      e.data = (idx < DEPTH) ? mm[idx] : '0;
      e.resp = (err || idx >= DEPTH) ? 2'b10 : 2'b00;
      e.last = (k == len);
      r_exp.push_back(e);
    end
    S_AXI_ARID = id; S_AXI_ARADDR = addr[AW-1:0]; S_AXI_ARLEN = len[7:0]; S_AXI_ARBURST = burst;
    S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!S_AXI_ARREADY && t < 50) begin step(); t++; end
    chk("ar_wait", 64'(t < 50), 64'd1);
    step();                                   // just past AR handshake edge N
    S_AXI_ARVALID = 1'b0;
    if (chk_lat) begin
      chk("arready_low_after_ar", 64'(S_AXI_ARREADY), 64'd0);
      chk("rvalid_after_N", 64'(S_AXI_RVALID), 64'd0);
      step();
      chk("rvalid_after_N1", 64'(S_AXI_RVALID), 64'd0);
      step();
      chk("rvalid_after_N2", 64'(S_AXI_RVALID), 64'd1);
    end
  endtask

  task automatic wait_r_done();
    int t;
    t = 0;
    while (r_exp.size() != 0 && t < 500) begin step(); t++; end
    chk("r_burst_complete", 64'(r_exp.size()), 64'd0);
    chk("arready_after_last_r", 64'(S_AXI_ARREADY), 64'd1);
  endtask

  // ---------------- RREADY driver ----------------
  initial begin
    S_AXI_RREADY = 1'b1;
    forever begin
      step();
      S_AXI_RREADY = rr_toggle ? ~S_AXI_RREADY : 1'b1;
    end
  end

  // ---------------- monitor / compare ----------------
  initial begin
    rbeat_t cur, prev, e;
    bbeat_t be;
    bit stall;
    stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        r_exp.delete(); b_exp.delete(); stall = 1'b0;
        continue;
      end
      cur.id = S_AXI_RID; cur.data = S_AXI_RDATA; cur.resp = S_AXI_RRESP; cur.last = S_AXI_RLAST;
      if (S_AXI_RVALID) begin
        if (stall) chk("r_hold_while_stalled", 64'(cur), 64'(prev));
        if (S_AXI_RREADY) begin
          r_seen++;
          if (r_exp.size() == 0) chk("r_unexpected_beat", 64'd1, 64'd0);
          else begin
            e = r_exp.pop_front();
            chk("rid", 64'(cur.id), 64'(e.id));
            chk("rdata", 64'(cur.data), 64'(e.data));
            chk("rresp", 64'(cur.resp), 64'(e.resp));
            chk("rlast", 64'(cur.last), 64'(e.last));
            r_log.push_back(cur);
          end
        end
      end
      stall = S_AXI_RVALID && !S_AXI_RREADY;
      prev = cur;
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (b_exp.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
        else begin
          be = b_exp.pop_front();
          chk("bid", 64'(S_AXI_BID), 64'(be.id));
          chk("bresp", 64'(S_AXI_BRESP), 64'(be.resp));
        end
        last_bresp = S_AXI_BRESP;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base, t;
    ARESET = 1'b1;
    step(); step();
    chk("rst_ready_valid", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}), 64'd0);
    chk("rst_ids_resps", 64'({S_AXI_BID, S_AXI_RID, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RLAST}), 64'd0);
    chk("rst_rdata", 64'(S_AXI_RDATA), 64'd0);
    ARESET = 1'b0;
    step();
    chk("awready_after_reset", 64'(S_AXI_AWREADY), 64'd1);
    chk("arready_after_reset", 64'(S_AXI_ARREADY), 64'd1);

    // 1: INCR 8-beat write then read back
    for (int k = 0; k < 8; k++) wdat[k] = 32'(k + 1);
    do_write(4'h3, 'h000, 7, 2'b01, 4'hF, -1);
    chk("t1_bresp", 64'(last_bresp), 64'h0);
    r_log.delete();
    do_read(4'h5, 'h000, 7, 2'b01, 1'b1);
    wait_r_done();
    for (int k = 0; k < 8; k++) begin
      chk("t1_data_lit", 64'(r_log[k].data), 64'(k + 1));
      chk("t1_last_lit", 64'(r_log[k].last), 64'(k == 7));
    end

    // 2: WRAP len 3 at 0x08 -> words 2,3,0,1
    wdat[0] = 32'hAAAA000A; wdat[1] = 32'hBBBB000B; wdat[2] = 32'hCCCC000C; wdat[3] = 32'hDDDD000D;
    do_write(4'h1, 'h008, 3, 2'b10, 4'hF, -1);
    r_log.delete();
    do_read(4'h1, 'h000, 3, 2'b01, 1'b0);
    wait_r_done();
    chk("t2_w0_lit", 64'(r_log[0].data), 64'hCCCC000C);
    chk("t2_w1_lit", 64'(r_log[1].data), 64'hDDDD000D);
    chk("t2_w2_lit", 64'(r_log[2].data), 64'hAAAA000A);
    chk("t2_w3_lit", 64'(r_log[3].data), 64'hBBBB000B);

    // 3: strobes and FIXED
    wdat[0] = 32'hFFFFFFFF;
    do_write(4'h2, 'h010, 0, 2'b01, 4'hF, -1);
    wdat[0] = 32'h11223344;
    do_write(4'h2, 'h010, 0, 2'b01, 4'b0101, -1);
    r_log.delete();
    do_read(4'h2, 'h010, 0, 2'b01, 1'b0);
    wait_r_done();
    chk("t3_strobe_lit", 64'(r_log[0].data), 64'hFF22FF44);
    for (int k = 0; k < 4; k++) wdat[k] = 32'hB0 + 32'(k);
    do_write(4'h2, 'h010, 3, 2'b00, 4'hF, -1);
    r_log.delete();
    do_read(4'h2, 'h010, 0, 2'b01, 1'b0);
    wait_r_done();
    chk("t3_fixed_lit", 64'(r_log[0].data), 64'hB3);

    // 4: 16-beat read with RREADY toggling, concurrent 4-beat write elsewhere
    for (int k = 0; k < 16; k++) wdat[k] = 32'h1000 + 32'(k);
    do_write(4'h4, 'h100, 15, 2'b01, 4'hF, -1);
    for (int k = 0; k < 4; k++) wdat[k] = 32'h2000 + 32'(k);
    r_log.delete();
    rr_toggle = 1'b1;
    fork
      begin do_read(4'h9, 'h100, 15, 2'b01, 1'b0); wait_r_done(); end
      begin do_write(4'hA, 'h200, 3, 2'b01, 4'hF, -1); end
    join
    rr_toggle = 1'b0;
    step();
    chk("t4_beats", 64'(r_log.size()), 64'd16);
    for (int k = 0; k < 16 && k < r_log.size(); k++) chk("t4_order_lit", 64'(r_log[k].data), 64'h1000 + 64'(k));
    chk("t4_bresp", 64'(last_bresp), 64'h0);

    // 5: INCR running off the top of memory
    for (int k = 0; k < 4; k++) wdat[k] = 32'h5000 + 32'(k);
    do_write(4'h6, 'hFF8, 3, 2'b01, 4'hF, -1);
    chk("t5_bresp_lit", 64'(last_bresp), 64'h2);
    r_log.delete();
    do_read(4'h6, 'hFF8, 3, 2'b01, 1'b0);
    wait_r_done();
    chk("t5_resp_lit", 64'({r_log[0].resp, r_log[1].resp, r_log[2].resp, r_log[3].resp}), 64'b00_00_10_10);
    chk("t5_data_lit", 64'({r_log[0].data, r_log[1].data}), 64'h00005000_00005001);
    chk("t5_oor_zero_lit", 64'({r_log[2].data, r_log[3].data}), 64'h0);

    // WLAST early, and reserved burst type (handled as INCR)
    wdat[0] = 32'h4400; wdat[1] = 32'h4401;
    do_write(4'h7, 'h040, 1, 2'b01, 4'hF, 0);
    chk("wlast_err_lit", 64'(last_bresp), 64'h2);
    wdat[0] = 32'h6600; wdat[1] = 32'h6601;
    do_write(4'h8, 'h060, 1, 2'b11, 4'hF, -1);
    chk("reserved_err_lit", 64'(last_bresp), 64'h2);
    r_log.delete();
    do_read(4'h8, 'h060, 1, 2'b01, 1'b0);
    wait_r_done();
    chk("reserved_as_incr_lit", 64'({r_log[0].data, r_log[1].data}), 64'h00006600_00006601);

    // 6: reset in the middle of an 8-beat read
    base = r_seen;
    do_read(4'hC, 'h000, 7, 2'b01, 1'b0);
    t = 0;
    while (r_seen < base + 3 && t < 100) begin step(); t++; end
    chk("t6_three_beats", 64'(r_seen - base), 64'd3);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    chk("t6_rvalid_after_reset", 64'(S_AXI_RVALID), 64'd0);
    step();
    chk("t6_rvalid_stays_low", 64'(S_AXI_RVALID), 64'd0);
    chk("t6_arready_after_release", 64'(S_AXI_ARREADY), 64'd1);
    r_log.delete();
    do_read(4'hD, 'h000, 7, 2'b01, 1'b0);
    wait_r_done();
    chk("t6_word7_lit", 64'(r_log[7].data), 64'h8);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
